// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words over a req/ack handshake
// and presents them to the decoder. Optional jump predecode: FETCH_JUMP_PREDECODE_EN.
module fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] ins_pc,
  output logic [ADDR_W-1:0] ins_pc_plus1
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_ir_valid;
  logic [ADDR_W-1:0] r_ir_pc;

  logic              w_blocked;
  logic [ADDR_W-1:0] w_capture_pc;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // A live instruction that downstream cannot take blocks any new request.
  assign w_blocked = r_ir_valid & stall;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic w_is_jump;
  assign w_is_jump    = (imem_rdata[31:27] == 5'b00001) || (imem_rdata[31:27] == 5'b00011);
  assign w_capture_pc = w_is_jump ? imem_rdata[ADDR_W-1:0] : pc_inc(r_pc);
`else
  assign w_capture_pc = pc_inc(r_pc);
`endif

  assign imem_req     = (r_state == ST_FETCH) & ~w_blocked;
  assign imem_addr    = r_pc;
  assign ins          = r_ir;
  assign ins_valid    = r_ir_valid;
  assign ins_pc       = r_ir_pc;
  assign ins_pc_plus1 = pc_inc(r_ir_pc);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RST;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_ir_pc    <= RESET_PC;
    end else if (redirect) begin
      // Redirect overrides everything; a coincident ack is dropped.
      r_pc       <= redirect_pc;
      r_ir_valid <= 1'b0;
      r_state    <= ST_FETCH;
    end else begin
      case (r_state)
        ST_RST: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (w_blocked) begin
            r_state <= ST_HOLD;
          end else if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_ir_pc    <= r_pc;
            r_ir_valid <= 1'b1;
            r_pc       <= w_capture_pc;
          end else if (r_ir_valid) begin
            r_ir_valid <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            r_ir_valid <= 1'b0;
            r_state    <= ST_FETCH;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory model
// whose ack latency is programmable per test.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [11:0] redirect_pc;
  logic [31:0] ins;
  logic        ins_valid;
  logic [11:0] ins_pc;
  logic [11:0] ins_pc_plus1;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int wait_cnt = 0;
  logic jtest = 1'b0;
  logic [11:0] exp_after_jump;

  fetch_unit #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ins(ins), .ins_valid(ins_valid), .ins_pc(ins_pc), .ins_pc_plus1(ins_pc_plus1)
  );

  always #5 clock = ~clock;

  // Memory returns the word address as data, except a j instruction at 0x010 in jump tests.
  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= lat - 1);
    imem_rdata = (jtest && imem_addr == 12'h010) ? 32'h0800_0123 : {20'b0, imem_addr};
  end

  always @(posedge clock) begin
    if (!imem_req || imem_ack || redirect) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clock);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr: got %h want 000", imem_addr); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL rst_ins: got %h want 0", ins); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ins_valid); end
    checks++; if (ins_pc !== 12'h000) begin errors++; $display("FAIL rst_pc: got %h want 000", ins_pc); end
    checks++; if (ins_pc_plus1 !== 12'h001) begin errors++; $display("FAIL rst_pc1: got %h want 001", ins_pc_plus1); end
  endtask

  task automatic test_zero_wait();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_first_req: got %b want 1", imem_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL zw_first_valid: got %b want 0", ins_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b want 1", k, ins_valid); end
      checks++; if (ins !== 32'(k)) begin errors++; $display("FAIL zw_ins[%0d]: got %h want %h", k, ins, k); end
      checks++; if (ins_pc !== 12'(k)) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", k, ins_pc, k); end
      checks++; if (ins_pc_plus1 !== 12'(k + 1)) begin errors++; $display("FAIL zw_pc1[%0d]: got %h want %h", k, ins_pc_plus1, k + 1); end
    end
  endtask

  task automatic test_stall();
    @(negedge clock);
    @(negedge clock);
    checks++; if (ins !== 32'h5) begin errors++; $display("FAIL st_pre: got %h want 5", ins); end
    stall = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop: got %b want 0", imem_req); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if (ins !== 32'h5 || ins_valid !== 1'b1) begin errors++; $display("FAIL st_hold[%0d]: got %h/%b want 5/1", i, ins, ins_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d]: got %b want 0", i, imem_req); end
    end
    stall = 1'b0;
    @(negedge clock);
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL st_bubble: got %b want 0", ins_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 12'h006) begin errors++; $display("FAIL st_resume: got %b/%h want 1/006", imem_req, imem_addr); end
    @(negedge clock);
    checks++; if (ins !== 32'h6 || ins_valid !== 1'b1 || ins_pc !== 12'h006) begin errors++; $display("FAIL st_next: got %h/%b/%h want 6/1/006", ins, ins_valid, ins_pc); end
  endtask

  task automatic test_redirect();
    checks++; if (imem_addr !== 12'h007 || imem_ack !== 1'b1) begin errors++; $display("FAIL rd_pre: got %h/%b want 007/1", imem_addr, imem_ack); end
    redirect = 1'b1; redirect_pc = 12'h040;
    @(negedge clock);
    redirect = 1'b0;
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rd_valid: got %b want 0", ins_valid); end
    checks++; if (ins !== 32'h6 || ins_pc !== 12'h006) begin errors++; $display("FAIL rd_drop: got %h/%h want 6/006", ins, ins_pc); end
    checks++; if (imem_addr !== 12'h040 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_addr: got %h/%b want 040/1", imem_addr, imem_req); end
    @(negedge clock);
    checks++; if (ins_pc !== 12'h040 || ins !== 32'h40 || ins_valid !== 1'b1) begin errors++; $display("FAIL rd_next: got %h/%h/%b want 040/40/1", ins_pc, ins, ins_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 12'hFFF;
    @(negedge clock);
    redirect = 1'b0;
    checks++; if (imem_addr !== 12'hFFF) begin errors++; $display("FAIL wr_addr: got %h want fff", imem_addr); end
    @(negedge clock);
    checks++; if (ins_pc !== 12'hFFF || ins !== 32'hFFF) begin errors++; $display("FAIL wr_ins: got %h/%h want fff/fff", ins_pc, ins); end
    checks++; if (ins_pc_plus1 !== 12'h000) begin errors++; $display("FAIL wr_pc1: got %h want 000", ins_pc_plus1); end
    checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL wr_next_addr: got %h want 000", imem_addr); end
  endtask

  task automatic test_delayed_ack();
    redirect = 1'b1; redirect_pc = 12'h100; lat = 3;
    @(posedge clock);
    #1 redirect = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        checks++; if (imem_addr !== 12'(12'h100 + r) || imem_req !== 1'b1) begin errors++; $display("FAIL dl_addr[%0d.%0d]: got %h/%b want %h/1", r, c, imem_addr, imem_req, 12'h100 + r); end
        if (r > 0) begin
          checks++; if (ins !== 32'(32'h100 + r - 1) || ins_valid !== (c == 0)) begin errors++; $display("FAIL dl_ins[%0d.%0d]: got %h/%b want %h/%b", r, c, ins, ins_valid, 32'h100 + r - 1, c == 0); end
        end
      end
    end
    @(negedge clock);
    checks++; if (ins !== 32'h102 || ins_pc !== 12'h102 || ins_valid !== 1'b1) begin errors++; $display("FAIL dl_last: got %h/%h/%b want 102/102/1", ins, ins_pc, ins_valid); end
    lat = 1;
  endtask

  task automatic test_predecode();
`ifdef FETCH_JUMP_PREDECODE_EN
    exp_after_jump = 12'h123;
`else
    exp_after_jump = 12'h011;
`endif
    jtest = 1'b1;
    redirect = 1'b1; redirect_pc = 12'h010;
    @(negedge clock);
    redirect = 1'b0;
    checks++; if (imem_addr !== 12'h010) begin errors++; $display("FAIL jp_addr: got %h want 010", imem_addr); end
    @(negedge clock);
    checks++; if (ins !== 32'h0800_0123 || ins_pc !== 12'h010) begin errors++; $display("FAIL jp_ins: got %h/%h want 08000123/010", ins, ins_pc); end
    checks++; if (imem_addr !== exp_after_jump) begin errors++; $display("FAIL jp_next_addr: got %h want %h", imem_addr, exp_after_jump); end
    @(negedge clock);
    checks++; if (ins_pc !== exp_after_jump) begin errors++; $display("FAIL jp_next_pc: got %h want %h", ins_pc, exp_after_jump); end
    jtest = 1'b0;
  endtask

  task automatic test_reset_mid();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_pre: got %b want 1", imem_req); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 12'h000) begin errors++; $display("FAIL rm_req: got %b/%h want 0/000", imem_req, imem_addr); end
    checks++; if (ins !== 32'h0 || ins_valid !== 1'b0 || ins_pc !== 12'h000) begin errors++; $display("FAIL rm_ir: got %h/%b/%h want 0/0/000", ins, ins_valid, ins_pc); end
    @(negedge clock);
    checks++; if (ins !== 32'h0 || ins_valid !== 1'b0) begin errors++; $display("FAIL rm_hold: got %h/%b want 0/0", ins, ins_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_redirect();
    test_wrap();
    test_delayed_ack();
    test_predecode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-bit-opcode processor, sitting directly upstream of the instruction decoder. It owns the program counter and issues word requests to instruction memory over a variable-latency request/acknowledge handshake. It holds the returned word in an instruction register presented to the decoder with a valid flag, and absorbs downstream stalls and branch/jump redirects.

## Interface
- ADDR_W, 12, instruction-memory word-address width; PC width.
- RESET_PC, 0, PC value loaded on reset.

- clock  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- imem_req  output  1  request strobe to instruction memory.
- imem_addr  output  ADDR_W  word address of the current request.
- imem_ack  input  1  imem_rdata is valid for the imem_addr presented this cycle.
- imem_rdata  input  32  instruction word.
- stall  input  1  downstream cannot accept; hold ins/ins_valid.
- redirect  input  1  taken branch/jump from execute; single-cycle pulse.
- redirect_pc  input  ADDR_W  redirect target.
- ins  output  32  instruction register, feeds decoder ins.
- ins_valid  output  1  ins holds a live instruction.
- ins_pc  output  ADDR_W  address ins was fetched from.
- ins_pc_plus1  output  ADDR_W  ins_pc + 1, used for jal/branch base.

## Operation
- Registers: pc (next fetch address), ir, ir_valid, ir_pc, 2-bit state.
- States: RST, FETCH, HOLD.
  - RST: entered on reset; imem_req=0. Next cycle: FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack with IR accepting (¬ir_valid ∨ ¬stall): ir←imem_rdata, ir_pc←pc, ir_valid←1, pc←pc+1, stay in FETCH. If ir_valid ∧ stall: imem_req=0 this cycle, go to HOLD. On ack, this check uses the same-cycle stall.
  - HOLD: imem_req=0; ir and ir_valid unchanged. When ¬stall: ir_valid←0, go to FETCH.
- When ir_valid ∧ ¬stall in FETCH with no ack, ir_valid←0 because the instruction was consumed.
- Redirect has priority over everything: pc←redirect_pc, ir_valid←0, state←FETCH. Any imem_ack in the same cycle is discarded; ir and pc are not updated from it.
- imem_addr may change while imem_req is high only via redirect. The memory holds no in-flight state, so a dropped ack needs no cleanup.
- PC arithmetic is modulo 2^ADDR_W: pc = all-ones increments to 0.
- ins_pc_plus1 is combinational ir_pc+1, also modulo 2^ADDR_W.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, ins=0, ins_valid=0, ins_pc=RESET_PC, ins_pc_plus1=RESET_PC+1, state=RST.
- First request: imem_req rises on the first clock edge after reset deasserts.
- Zero-wait memory (ack same cycle as req): one instruction per cycle. ins_valid first rises on the second edge after reset release.
- Ack-to-ins latency: 1 cycle; ins updates on the edge where ack is sampled.
- Redirect-to-request: imem_addr=redirect_pc on the cycle after the redirect pulse. ins_valid is low for at least that cycle.
- Stall: ins is stable for every cycle stall is high with ins_valid=1; no word is lost or duplicated.
- Reset asserted mid-request: outputs take reset values asynchronously; an outstanding ack is ignored.

## Configuration
- FETCH_JUMP_PREDECODE_EN defined:
  - On a captured word with opcode ins[31:27] = 00001 (j) or 00011 (jal), the next-cycle pc becomes ins[ADDR_W-1:0], not pc+1.
  - This saves the execute-stage redirect bubble.
  - An external redirect in the same cycle still wins.
- Undefined: no predecode; jumps rely solely on redirect, and pc always increments.

## Test plan
- Reset, zero-wait memory returning the word address as data → ins_valid high from cycle 2; ins = 0,1,2,3 on consecutive cycles; ins_pc matches ins.
- Ack delayed 3 cycles per request → imem_addr is stable for 3 cycles; ins updates once per request; no skipped addresses.
- stall high 4 cycles while ins=0x0000_0005 valid → imem_req drops, then state is HOLD. ins holds 5 for 4 cycles; the next ins is 6 after release.
- redirect to 0x040 coincident with ack of address 7 → word 7 dropped, ins_valid low one cycle, imem_addr=0x040, next ins_pc=0x040.
- pc at 0xFFF with ack → next imem_addr=0x000; ins_pc_plus1 for 0xFFF reads 0x000.
- With FETCH_JUMP_PREDECODE_EN: fetch a j instruction (0x0800_0123) at 0x010 → next imem_addr=0x123 and 0x011 is never requested. Without the macro: 0x011 is requested.
